register_bank_inc: RTL and testbench

Parametrised bank of CHANNELS independent N-bit counter registers, each loadable, incrementable and decrementable by a programmable step, with wrap or saturate overflow handling. One channel is selected for modification per cycle and one for reading onto the shared bus, which is gated to zero when not read. It is the bus-facing pointer/counter storage (program counter, stack and index pointers) of the datapath.

---
 rtl/register_pkg.sv | 22 ++
 rtl/register_inc_cell.sv | 72 +++++++
 rtl/register_bank_inc.sv | 76 +++++++
 tb/tb_register_bank_inc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared types for the register bank: per-cycle operation encoding and its decode.
package register_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

    // Load wins; inc and dec together cancel to a hold.
    function automatic op_e decode_op(input logic write, input logic inc, input logic dec);
        if (write)
            return OP_LOAD;
        if (inc && !dec)
            return OP_INC;
        if (dec && !inc)
            return OP_DEC;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/register_inc_cell.sv
// One counter channel: load/inc/dec by step with wrap or saturate, boundary flag.
// Sticky overflow flag present only when REGISTER_BANK_INC_OVF_EN is defined.
module register_inc_cell
    import register_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned STEP_W   = 2,
    parameter int unsigned SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  op_e               op,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      data_in,
    output logic [N-1:0]      value,
    output logic              wrap
`ifdef REGISTER_BANK_INC_OVF_EN
    ,
    input  logic              ovf_clr,
    output logic              ovf
`endif
);

    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] nxt_value;
    logic         nxt_wrap;

    // Next value; bit N of sum/diff is the carry/borrow out of the range.
    always_comb begin
        sum       = {1'b0, value} + (N+1)'(step);
        diff      = {1'b0, value} - (N+1)'(step);
        nxt_value = value;
        nxt_wrap  = 1'b0;
        if (sel) begin
            case (op)
                OP_LOAD: nxt_value = data_in;
                OP_INC: begin
                    nxt_wrap  = sum[N];
                    nxt_value = (SATURATE != 0 && sum[N]) ? '1 : sum[N-1:0];
                end
                OP_DEC: begin
                    nxt_wrap  = diff[N];
                    nxt_value = (SATURATE != 0 && diff[N]) ? '0 : diff[N-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            value <= nxt_value;
            wrap  <= nxt_wrap;
        end
    end

`ifdef REGISTER_BANK_INC_OVF_EN
    // A new boundary event takes precedence over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else
            ovf <= nxt_wrap | (ovf & ~ovf_clr);
    end
`endif

endmodule

// File: rtl/register_bank_inc.sv
// Bank of CHANNELS step counters with one write channel and one gated read port per cycle.
// Optional sticky per-channel overflow flags: define REGISTER_BANK_INC_OVF_EN.
module register_bank_inc
    import register_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned STEP_W   = 2,
    parameter int unsigned SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic                        inc,
    input  logic                        dec,
    input  logic [STEP_W-1:0]           step,
    input  logic [$clog2(CHANNELS)-1:0] sel_w,
    input  logic                        read,
    input  logic [$clog2(CHANNELS)-1:0] sel_r,
    input  logic [N-1:0]                data_in,
    output logic [N-1:0]                data_out,
    output logic [CHANNELS-1:0]         zero,
    output logic                        wrap
`ifdef REGISTER_BANK_INC_OVF_EN
    ,
    output logic [CHANNELS-1:0]         ovf,
    input  logic [CHANNELS-1:0]         ovf_clr
`endif
);

    localparam int unsigned SEL_W = $clog2(CHANNELS);

    op_e                 op;
    logic [N-1:0]        vals [CHANNELS];
    logic [CHANNELS-1:0] cell_wrap;

    assign op = decode_op(write, inc, dec);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        register_inc_cell #(
            .N        (N),
            .STEP_W   (STEP_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .sel     (sel_w == SEL_W'(i)),
            .op      (op),
            .step    (step),
            .data_in (data_in),
            .value   (vals[i]),
            .wrap    (cell_wrap[i])
`ifdef REGISTER_BANK_INC_OVF_EN
            ,
            .ovf_clr (ovf_clr[i]),
            .ovf     (ovf[i])
`endif
        );
        assign zero[i] = (vals[i] == '0);
    end

    // Only the selected cell can raise its flag, so the OR is still a single pulse.
    assign wrap = |cell_wrap;

    // Out-of-range sel_r matches no channel and reads back zero.
    always_comb begin
        data_out = '0;
        if (read) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_r == SEL_W'(i))
                    data_out = vals[i];
            end
        end
    end

endmodule

// File: tb/tb_register_bank_inc.sv
// Scoreboard bench for register_bank_inc: a wrap-mode and a saturate-mode instance share stimulus.
module tb_register_bank_inc;

    logic       clk = 1'b0;
    logic       rst;
    logic       write, inc, dec, read;
    logic [1:0] step, sel_w, sel_r;
    logic [7:0] data_in;
    logic [7:0] dout_w, dout_s;
    logic [3:0] zero_w, zero_s;
    logic       wrap_w, wrap_s;
`ifdef REGISTER_BANK_INC_OVF_EN
    logic [3:0] ovf_w, ovf_s, ovf_clr;
`endif

    always #5 clk = ~clk;

    register_bank_inc #(.N(8), .CHANNELS(4), .STEP_W(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .write(write), .inc(inc), .dec(dec), .step(step),
        .sel_w(sel_w), .read(read), .sel_r(sel_r), .data_in(data_in),
        .data_out(dout_w), .zero(zero_w), .wrap(wrap_w)
`ifdef REGISTER_BANK_INC_OVF_EN
        , .ovf(ovf_w), .ovf_clr(ovf_clr)
`endif
    );

    register_bank_inc #(.N(8), .CHANNELS(4), .STEP_W(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .write(write), .inc(inc), .dec(dec), .step(step),
        .sel_w(sel_w), .read(read), .sel_r(sel_r), .data_in(data_in),
        .data_out(dout_s), .zero(zero_s), .wrap(wrap_s)
`ifdef REGISTER_BANK_INC_OVF_EN
        , .ovf(ovf_s), .ovf_clr(ovf_clr)
`endif
    );

    typedef struct {
        logic [7:0] wo;
        logic [3:0] wz;
        logic       ww;
        logic [7:0] so;
        logic [3:0] sz;
        logic       sw;
        logic [3:0] clr;
        logic [3:0] ov;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one op for exactly one rising edge and queue its post-edge expectation.
    task automatic vec(input logic wr, input logic in, input logic de, input logic [1:0] st,
                       input logic [1:0] sw_, input logic rd, input logic [1:0] sr,
                       input logic [7:0] din, input logic [3:0] oc,
                       input logic [7:0] wo, input logic [3:0] wz, input logic ww,
                       input logic [7:0] so, input logic [3:0] sz, input logic sww,
                       input logic [3:0] ov);
        exp_t e;
        @(negedge clk);
        #1;
        write = wr; inc = in; dec = de; step = st; sel_w = sw_;
        read = rd; sel_r = sr; data_in = din;
`ifdef REGISTER_BANK_INC_OVF_EN
        ovf_clr = oc;
`endif
        e.wo = wo; e.wz = wz; e.ww = ww; e.so = so; e.sz = sz; e.sw = sww;
        e.clr = oc; e.ov = ov;
        q.push_back(e);
    endtask

    task automatic idle();
        write = 0; inc = 0; dec = 0; step = 0; sel_w = 0;
        read = 0; sel_r = 0; data_in = 0;
`ifdef REGISTER_BANK_INC_OVF_EN
        ovf_clr = 0;
`endif
    endtask

    // Monitor: compare the outputs settled after each edge against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0 && !rst) begin
            exp_t e;
            e = q.pop_front();
            chk("data_out_wrap", 32'(dout_w), 32'(e.wo));
            chk("zero_wrap",     32'(zero_w), 32'(e.wz));
            chk("wrap_wrap",     32'(wrap_w), 32'(e.ww));
            chk("data_out_sat",  32'(dout_s), 32'(e.so));
            chk("zero_sat",      32'(zero_s), 32'(e.sz));
            chk("wrap_sat",      32'(wrap_s), 32'(e.sw));
`ifdef REGISTER_BANK_INC_OVF_EN
            chk("ovf_wrap", 32'(ovf_w), 32'(e.ov));
            chk("ovf_sat",  32'(ovf_s), 32'(e.ov));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, queue depth %0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        read = 1; sel_r = 0;
        #1;
        chk("reset_data_out_wrap", 32'(dout_w), 32'h0);
        chk("reset_zero_wrap",     32'(zero_w), 32'hF);
        chk("reset_zero_sat",      32'(zero_s), 32'hF);
        chk("reset_wrap_flag",     32'(wrap_w | wrap_s), 32'h0);

        vec(1,0,0,0, 0,1,0, 8'h05, 4'h0,  8'h05,4'b1110,0, 8'h05,4'b1110,0, 4'h0);

        // Reset between edges with an op pending: immediate clear, op discarded.
        @(negedge clk);
        #1;
        write = 0; inc = 1; dec = 0; step = 1; sel_w = 0; read = 1; sel_r = 0;
        #2 rst = 1'b1;
        #1;
        chk("midreset_data_out_wrap", 32'(dout_w), 32'h0);
        chk("midreset_data_out_sat",  32'(dout_s), 32'h0);
        chk("midreset_zero_wrap",     32'(zero_w), 32'hF);
        chk("midreset_zero_sat",      32'(zero_s), 32'hF);
        @(negedge clk);
        #1 rst = 1'b0;
        idle();

        vec(0,1,0,2, 0,1,0, 8'h00, 4'h0,  8'h02,4'b1110,0, 8'h02,4'b1110,0, 4'h0);
        vec(0,0,1,2, 0,1,0, 8'h00, 4'h0,  8'h00,4'b1111,0, 8'h00,4'b1111,0, 4'h0);
        // Load then inc across the top boundary.
        vec(1,0,0,0, 1,1,1, 8'hFE, 4'h0,  8'hFE,4'b1101,0, 8'hFE,4'b1101,0, 4'h0);
        vec(0,1,0,1, 1,1,1, 8'h00, 4'h0,  8'hFF,4'b1101,0, 8'hFF,4'b1101,0, 4'h0);
        vec(0,1,0,1, 1,1,1, 8'h00, 4'h0,  8'h00,4'b1111,1, 8'hFF,4'b1101,1, 4'h2);
        vec(0,0,0,0, 1,1,1, 8'h00, 4'h0,  8'h00,4'b1111,0, 8'hFF,4'b1101,0, 4'h2);
        // Dec below zero and inc by 3 past the top.
        vec(1,0,0,0, 2,1,2, 8'h01, 4'h0,  8'h01,4'b1011,0, 8'h01,4'b1001,0, 4'h2);
        vec(0,0,1,3, 2,1,2, 8'h00, 4'h0,  8'hFE,4'b1011,1, 8'h00,4'b1101,1, 4'h6);
        vec(1,0,0,0, 2,1,2, 8'hFE, 4'h0,  8'hFE,4'b1011,0, 8'hFE,4'b1001,0, 4'h6);
        vec(0,1,0,3, 2,1,2, 8'h00, 4'h0,  8'h01,4'b1011,1, 8'hFF,4'b1001,1, 4'h6);
        // Priority: write over inc; inc with dec holds.
        vec(1,1,0,1, 0,1,0, 8'h40, 4'h0,  8'h40,4'b1010,0, 8'h40,4'b1000,0, 4'h6);
        vec(0,1,1,2, 0,1,0, 8'h00, 4'h0,  8'h40,4'b1010,0, 8'h40,4'b1000,0, 4'h6);
        // Read gating and channel isolation.
        vec(1,0,0,0, 3,0,3, 8'hAA, 4'h0,  8'h00,4'b0010,0, 8'h00,4'b0000,0, 4'h6);
        vec(0,0,0,0, 3,1,3, 8'h00, 4'h0,  8'hAA,4'b0010,0, 8'hAA,4'b0000,0, 4'h6);
        vec(0,0,0,0, 3,1,0, 8'h00, 4'h0,  8'h40,4'b0010,0, 8'h40,4'b0000,0, 4'h6);
        vec(0,0,0,0, 3,1,1, 8'h00, 4'h0,  8'h00,4'b0010,0, 8'hFF,4'b0000,0, 4'h6);
        // Zero step leaves the value alone.
        vec(0,1,0,0, 3,1,3, 8'h00, 4'h0,  8'hAA,4'b0010,0, 8'hAA,4'b0000,0, 4'h6);
        vec(0,0,1,2, 3,1,3, 8'h00, 4'h0,  8'hA8,4'b0010,0, 8'hA8,4'b0000,0, 4'h6);
        vec(1,0,0,0, 3,1,3, 8'h11, 4'h0,  8'h11,4'b0010,0, 8'h11,4'b0000,0, 4'h6);
        #1;
        chk("same_cycle_old_wrap", 32'(dout_w), 32'hA8);
        chk("same_cycle_old_sat",  32'(dout_s), 32'hA8);

        @(negedge clk);
        #1 rst = 1'b1;
        idle();
        @(negedge clk);
        #1 rst = 1'b0;

        // Sticky overflow: set, hold, clear, set-beats-clear.
        vec(1,0,0,0, 0,1,0, 8'hFF, 4'h0,  8'hFF,4'b1110,0, 8'hFF,4'b1110,0, 4'h0);
        vec(0,1,0,1, 0,1,0, 8'h00, 4'h0,  8'h00,4'b1111,1, 8'hFF,4'b1110,1, 4'h1);
        for (int k = 0; k < 10; k++)
            vec(0,0,0,0, 0,1,0, 8'h00, 4'h0,  8'h00,4'b1111,0, 8'hFF,4'b1110,0, 4'h1);
        vec(0,0,0,0, 0,1,0, 8'h00, 4'h1,  8'h00,4'b1111,0, 8'hFF,4'b1110,0, 4'h0);
        vec(1,0,0,0, 0,1,0, 8'hFF, 4'h0,  8'hFF,4'b1110,0, 8'hFF,4'b1110,0, 4'h0);
        vec(0,1,0,1, 0,1,0, 8'h00, 4'h1,  8'h00,4'b1111,1, 8'hFF,4'b1110,1, 4'h1);
        vec(0,0,0,0, 0,1,0, 8'h00, 4'h0,  8'h00,4'b1111,0, 8'hFF,4'b1110,0, 4'h1);

        for (int k = 0; k < 5 && q.size() > 0; k++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
